// File: rtl/joust2_rom_loader_if.sv
// ioctl download, core read and ROM RAM signals shared by joust2_rom_loader and its neighbours.
// JOUST2_ROM_CHECKSUM_EN adds the rom_sum output.
interface joust2_rom_loader_if #(
  parameter int ROM_AW = 17
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [ROM_AW-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              core_rd;
  logic [ROM_AW-1:0] core_addr;
  logic [7:0]        core_dout;
  logic              core_valid;
  logic              core_reset;
  logic [ROM_AW-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we;
  logic [7:0]        ram_dout;
  logic              load_done;
`ifdef JOUST2_ROM_CHECKSUM_EN
  logic [15:0]       rom_sum;
`endif

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  core_rd, core_addr, ram_dout,
    output ioctl_wait, core_dout, core_valid, core_reset,
    output ram_addr, ram_din, ram_we, load_done
`ifdef JOUST2_ROM_CHECKSUM_EN
    , output rom_sum
`endif
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output core_rd, core_addr, ram_dout,
    input  ioctl_wait, core_dout, core_valid, core_reset,
    input  ram_addr, ram_din, ram_we, load_done
`ifdef JOUST2_ROM_CHECKSUM_EN
    , input rom_sum
`endif
  );
endinterface

// File: rtl/joust2_rom_loader.sv
// Sequences ioctl ROM download into the ROM RAM, arbitrates it against williams2 reads, holds core in reset.
// Optional JOUST2_ROM_CHECKSUM_EN: byte checksum output and load_done gated on matching ROM_SUM.
module joust2_rom_loader #(
  parameter int         ROM_AW    = 17,
  parameter int         ROM_BYTES = 114688,
  parameter logic [7:0] ROM_INDEX = 8'd0,
  parameter int         HOLD_CYC  = 16
`ifdef JOUST2_ROM_CHECKSUM_EN
  , parameter logic [15:0] ROM_SUM = 16'h0000
`endif
) (
  input logic                 clk_sys,
  input logic                 reset,
  joust2_rom_loader_if.master bus
);
  localparam int CNT_W = $clog2(ROM_BYTES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t            state;
  logic              buf_vld;
  logic [ROM_AW-1:0] buf_addr;
  logic [7:0]        buf_dat;
  logic [CNT_W-1:0]  byte_cnt;
  logic [7:0]        hold_cnt;
  logic              rd_p1;
  logic              ioctl_wait_q;
  logic              core_valid_q;
  logic [7:0]        core_dout_q;
  logic              core_reset_q;
  logic              load_done_q;
  logic              idx_match;
  logic              addr_ok;
  logic              wr_accept;
  logic              restart;
  logic              sum_ok;

`ifdef JOUST2_ROM_CHECKSUM_EN
  logic [15:0] rom_sum_q;
  assign sum_ok      = (ROM_SUM == 16'h0000) || (rom_sum_q == ROM_SUM);
  assign bus.rom_sum = rom_sum_q;
`else
  assign sum_ok = 1'b1;
`endif

  always_comb begin
    idx_match = (bus.ioctl_index == ROM_INDEX);
    addr_ok   = (32'(bus.ioctl_addr) < 32'(ROM_BYTES));
    wr_accept = (state == LOAD) && bus.ioctl_wr && idx_match && addr_ok;
    restart   = bus.ioctl_download && idx_match;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= IDLE;
      buf_vld      <= 1'b0;
      buf_addr     <= '0;
      buf_dat      <= '0;
      byte_cnt     <= '0;
      hold_cnt     <= '0;
      rd_p1        <= 1'b0;
      ioctl_wait_q <= 1'b0;
      core_valid_q <= 1'b0;
      core_dout_q  <= '0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
`ifdef JOUST2_ROM_CHECKSUM_EN
      rom_sum_q    <= '0;
`endif
    end else begin
      // The buffer reloads every cycle, so a full buffer drains into RAM
      // on the same edge that captures the next write.
      buf_vld      <= wr_accept;
      ioctl_wait_q <= wr_accept;
      rd_p1        <= 1'b0;
      core_valid_q <= 1'b0;
      if (wr_accept) begin
        buf_addr <= bus.ioctl_addr;
        buf_dat  <= bus.ioctl_dout;
        if (byte_cnt != CNT_W'(ROM_BYTES))
          byte_cnt <= byte_cnt + 1'b1;
`ifdef JOUST2_ROM_CHECKSUM_EN
        rom_sum_q <= rom_sum_q + {8'h00, bus.ioctl_dout};
`endif
      end

      case (state)
        IDLE: begin
          core_reset_q <= 1'b1;
          if (restart) begin
            state       <= LOAD;
            load_done_q <= 1'b0;
            byte_cnt    <= '0;
`ifdef JOUST2_ROM_CHECKSUM_EN
            rom_sum_q   <= '0;
`endif
          end
        end
        LOAD: begin
          if (!bus.ioctl_download && !buf_vld && !wr_accept) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == 8'(HOLD_CYC - 1)) begin
            if (sum_ok) begin
              state        <= RUN;
              core_reset_q <= 1'b0;
              load_done_q  <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (restart) begin
            // In-flight reads are dropped by leaving rd_p1/core_valid cleared.
            state        <= LOAD;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            byte_cnt     <= '0;
`ifdef JOUST2_ROM_CHECKSUM_EN
            rom_sum_q    <= '0;
`endif
          end else begin
            rd_p1        <= bus.core_rd;
            core_valid_q <= rd_p1;
            if (rd_p1)
              core_dout_q <= bus.ram_dout;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ioctl_wait = ioctl_wait_q;
  assign bus.core_valid = core_valid_q;
  assign bus.core_dout  = core_dout_q;
  assign bus.core_reset = core_reset_q;
  assign bus.load_done  = load_done_q;
  assign bus.ram_addr   = (state == RUN) ? bus.core_addr : buf_addr;
  assign bus.ram_din    = buf_dat;
  assign bus.ram_we     = buf_vld;
endmodule

// File: tb/tb_joust2_rom_loader.sv
// Directed bench for joust2_rom_loader: behavioural ROM RAM plus a read scoreboard.
module tb_joust2_rom_loader;
  localparam int AW   = 17;
  localparam int HOLD = 16;

  typedef struct {
    logic [7:0] dat;
    int         cyc;
  } rd_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc       = 0;
  int   pass_cnt  = 0;
  int   chk_cnt   = 0;
  int   valid_cnt = 0;
  int   v0;
  rd_t  sb[$];

  logic [7:0] mem     [0:2**AW-1] = '{default: 8'hA5};
  logic [7:0] exp_mem [0:2**AW-1] = '{default: 8'hA5};

  always #5 clk = ~clk;

  joust2_rom_loader_if #(.ROM_AW(AW)) bus ();

  joust2_rom_loader #(
    .ROM_AW   (AW),
    .ROM_BYTES(114688),
    .ROM_INDEX(8'd0),
    .HOLD_CYC (HOLD)
  ) dut (
    .clk_sys(clk),
    .reset  (reset),
    .bus    (bus)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_we)
      mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  always @(negedge clk) begin
    if (bus.core_valid) begin
      rd_t e;
      valid_cnt++;
      check("valid_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rd_data", 32'(bus.core_dout), 32'(e.dat));
        check("rd_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    if (bus.ioctl_index == 8'd0 && 32'(a) < 114688)
      exp_mem[a] = d;
    tick();
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_t e;
    bus.core_rd   = 1'b1;
    bus.core_addr = a;
    e.dat = exp_mem[a];
    e.cyc = cyc + 2;
    sb.push_back(e);
    tick();
    bus.core_rd = 1'b0;
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.core_rd        = 1'b0;
    bus.core_addr      = '0;

    repeat (3) tick();
    check("rst_core_reset", 32'(bus.core_reset), 32'd1);
    check("rst_load_done", 32'(bus.load_done), 32'd0);
    check("rst_ioctl_wait", 32'(bus.ioctl_wait), 32'd0);
    check("rst_core_valid", 32'(bus.core_valid), 32'd0);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_core_reset", 32'(bus.core_reset), 32'd1);

    // Reads outside RUN must never produce core_valid.
    bus.core_rd = 1'b1;
    bus.core_addr = 17'h5;
    tick();
    bus.core_rd = 1'b0;

    bus.ioctl_download = 1'b1;
    tick();
    check("load_core_reset", 32'(bus.core_reset), 32'd1);
    check("load_done_clr", 32'(bus.load_done), 32'd0);

    for (int n = 0; n < 256; n++) begin
      wr(AW'(n), 8'(n));
      repeat (3) tick();
    end

    for (int i = 0; i < 8; i++) begin
      wr(AW'(17'h100 + i), 8'(8'hC0 + i));
      check("wait_burst", 32'(bus.ioctl_wait), 32'd1);
    end
    tick();
    check("wait_idle", 32'(bus.ioctl_wait), 32'd0);

    bus.ioctl_index = 8'd1;
    wr(17'h20, 8'h99);
    check("wait_bad_index", 32'(bus.ioctl_wait), 32'd0);
    bus.ioctl_index = 8'd0;
    wr(17'h1C000, 8'h77);
    check("wait_bad_addr", 32'(bus.ioctl_wait), 32'd0);
    tick();

    bus.core_rd = 1'b1;
    bus.core_addr = 17'h10;
    tick();
    bus.core_rd = 1'b0;

    bus.ioctl_download = 1'b0;
    repeat (HOLD) tick();
    check("hold_core_reset", 32'(bus.core_reset), 32'd1);
    check("hold_load_done", 32'(bus.load_done), 32'd0);
    tick();
    check("run_core_reset", 32'(bus.core_reset), 32'd0);
    check("run_load_done", 32'(bus.load_done), 32'd1);
    tick();

    v0 = valid_cnt;
    rd(17'h10);
    rd(17'h11);
    rd(17'h12);
    repeat (4) tick();
    check("b2b_valid_count", 32'(valid_cnt - v0), 32'd3);

    for (int a = 0; a < 256; a++)
      rd(AW'(a));
    for (int a = 17'h100; a < 17'h108; a++)
      rd(AW'(a));
    rd(17'h20);
    rd(17'h1C000);
    repeat (4) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Re-download one cycle after a read: that read is aborted.
    v0 = valid_cnt;
    bus.core_rd = 1'b1;
    bus.core_addr = 17'h10;
    tick();
    bus.core_rd = 1'b0;
    bus.ioctl_download = 1'b1;
    tick();
    check("abort_core_reset", 32'(bus.core_reset), 32'd1);
    check("abort_load_done", 32'(bus.load_done), 32'd0);
    repeat (4) tick();
    check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);

    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 17'h30;
    bus.ioctl_dout = 8'h55;
    tick();
    bus.ioctl_wr = 1'b0;
    check("midload_wait", 32'(bus.ioctl_wait), 32'd1);
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    tick();
    check("midrst_ram_we", 32'(bus.ram_we), 32'd0);
    check("midrst_wait", 32'(bus.ioctl_wait), 32'd0);
    check("midrst_load_done", 32'(bus.load_done), 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    check("postrst_core_reset", 32'(bus.core_reset), 32'd1);
    check("postrst_load_done", 32'(bus.load_done), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
